// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of a 4-bit ALU.
// It accepts 12-bit instructions over a valid/ready handshake and owns a 4 x 4-bit
// register file. For each instruction it presents the operands to the ALU, writes the
// result back, and keeps the {C, V, Z, N} status flags.
//
// Instruction word: [11:9] op, [8] li, [7:6] rd, [5:4] rs, [3:0] rt/imm (rt = [1:0]).
//
// Sequencing:
//   - LI and illegal ops (op = 011) complete on the accept edge.
//   - ALU ops take one extra EXEC cycle. Write-back happens on the edge that ends EXEC.
//   - A result written by one instruction is already in the register file when the next
//     instruction's EXEC cycle reads it, so no bypass path is needed.
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_instr,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [3:0]  alu_result,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_result,
    output logic [1:0]  out_rd,
    output logic        out_err,
    output logic [3:0]  flags,
    input  logic [1:0]  dbg_addr,
    output logic [3:0]  dbg_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ILLEGAL = 3'b011;

    // Decoded fields of the incoming instruction word.
    logic [2:0] instr_op;
    logic       instr_li;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic [1:0] instr_rt;
    logic [3:0] instr_imm;
    logic       instr_illegal;

    assign instr_op      = in_instr[11:9];
    assign instr_li      = in_instr[8];
    assign instr_rd      = in_instr[7:6];
    assign instr_rs      = in_instr[5:4];
    assign instr_rt      = in_instr[1:0];
    assign instr_imm     = in_instr[3:0];
    // With li=1, op is irrelevant, so an LI is never treated as illegal.
    assign instr_illegal = ~instr_li & (instr_op == OP_ILLEGAL);

    // Control state.
    logic [1:0] state_reg;
    logic [1:0] state_next;

    // Fields of the ALU op currently in EXEC, latched at accept.
    logic [2:0] op_reg;
    logic [1:0] rd_reg;
    logic [1:0] rs_reg;
    logic [1:0] rt_reg;

    // Status flags and the completion record shown in DONE.
    logic [3:0] flags_reg;
    logic [3:0] out_result_reg;
    logic [1:0] out_rd_reg;
    logic       out_err_reg;

    // Register file.
    logic [3:0] rf_reg [4];

    logic       accept;
    logic       is_exec;

    // Register-file write port.
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] wr_sel;

    assign is_exec  = (state_reg == EXEC);
    // A completion that is being retired this cycle frees the stage for a new instruction.
    assign in_ready = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Two sources can write the register file: an accepted LI, or the end of EXEC.
    // They can never collide, because nothing is accepted while in EXEC.
    assign wr_en   = (accept & instr_li) | is_exec;
    assign wr_addr = is_exec ? rd_reg : instr_rd;
    assign wr_data = is_exec ? alu_result : instr_imm;

    // One-hot write select, one bit per register-file entry.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en & (wr_addr == 2'(gi));
        end
    endgenerate

    // Register file storage; reset clears every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rf_reg[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_sel[i]) begin
                    rf_reg[i] <= wr_data;
                end
            end
        end
    end

    // Next-state logic. Accepting from DONE follows the same paths as accepting from IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = (instr_li | instr_illegal) ? DONE : EXEC;
                end else if ((state_reg == DONE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            EXEC:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched operands, flags and the completion record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            op_reg         <= 3'd0;
            rd_reg         <= 2'd0;
            rs_reg         <= 2'd0;
            rt_reg         <= 2'd0;
            flags_reg      <= 4'd0;
            out_result_reg <= 4'd0;
            out_rd_reg     <= 2'd0;
            out_err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                if (instr_li) begin
                    out_result_reg <= instr_imm;
                    out_rd_reg     <= instr_rd;
                    out_err_reg    <= 1'b0;
                end else if (instr_illegal) begin
                    out_result_reg <= 4'd0;
                    out_rd_reg     <= instr_rd;
                    out_err_reg    <= 1'b1;
                end else begin
                    op_reg <= instr_op;
                    rd_reg <= instr_rd;
                    rs_reg <= instr_rs;
                    rt_reg <= instr_rt;
                end
            end else if (is_exec) begin
                out_result_reg <= alu_result;
                out_rd_reg     <= rd_reg;
                out_err_reg    <= 1'b0;
                // C and V are taken raw from the ALU even for AND/OR ops.
                flags_reg      <= {alu_cout, alu_overflow, alu_zero, alu_result[3]};
            end
        end
    end

    // The ALU sees operands only while an op is in EXEC, and zeros at all other times.
    assign alu_a  = is_exec ? rf_reg[rs_reg] : 4'd0;
    assign alu_b  = is_exec ? rf_reg[rt_reg] : 4'd0;
    assign alu_op = is_exec ? op_reg : 3'd0;

    assign out_valid  = (state_reg == DONE);
    assign out_result = out_result_reg;
    assign out_rd     = out_rd_reg;
    assign out_err    = out_err_reg;
    assign flags      = flags_reg;
    assign dbg_data   = rf_reg[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage, including a behavioural model of the ripple 4-bit ALU.
// It applies a directed vector table, then hand-written sequences for backpressure,
// back-to-back read-after-write, and reset during EXEC.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_instr;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_result;
    logic        alu_cout;
    logic        alu_overflow;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_result;
    logic [1:0]  out_rd;
    logic        out_err;
    logic [3:0]  flags;
    logic [1:0]  dbg_addr;
    logic [3:0]  dbg_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    alu_issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_err      (out_err),
        .flags        (flags),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ripple ALU.
    // op[2] inverts b and supplies the carry-in; op[1:0] selects AND/OR/ADD/SLT.
    // The set output is looped back into the less input, so SLT returns {000, sum[3]}.
    logic [3:0] m_bb;
    logic [4:0] m_sum;
    logic [3:0] m_res;
    always_comb begin
        m_bb  = alu_op[2] ? ~alu_b : alu_b;
        m_sum = {1'b0, alu_a} + {1'b0, m_bb} + {4'd0, alu_op[2]};
        m_res = 4'd0;
        case (alu_op[1:0])
            2'b00: m_res = alu_a & m_bb;
            2'b01: m_res = alu_a | m_bb;
            2'b10: m_res = m_sum[3:0];
            2'b11: m_res = {3'b000, m_sum[3]};
            default: m_res = 4'd0;
        endcase
        alu_result   = m_res;
        alu_cout     = m_sum[4];
        alu_overflow = (alu_a[3] == m_bb[3]) && (m_sum[3] != alu_a[3]);
        alu_zero     = (m_res == 4'd0);
    end

    // Safety net in case the run never reaches its summary line.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    function automatic logic [11:0] enc(input logic [2:0] op, input logic li,
                                        input logic [1:0] rd, input logic [1:0] rs,
                                        input logic [3:0] rt);
        return {op, li, rd, rs, rt};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the stage accepts the word.
    // Returns 1 time unit after the accept edge, with in_valid dropped.
    task automatic issue(input logic [11:0] w);
        int n;
        in_instr = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: in_ready=0 after %0d cycles, required 1", n);
        end
        step();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [11:0] instr;
        logic [3:0]  res;
        logic [1:0]  rd;
        logic        err;
        logic [3:0]  fl;
        logic [3:0]  dbg;  // rf[rd] after completion
    } vec_t;

    vec_t vt[16];
    int   t_first;
    int   t_last;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 12'd0;
        out_ready = 1'b0;
        dbg_addr  = 2'd0;

        // Expected values are worked by hand: flags are {C, V, Z, N}, and LI leaves them unchanged.
        vt[0]  = '{enc(3'b000, 1'b1, 2'd1, 2'd0, 4'h7), 4'h7, 2'd1, 1'b0, 4'b0000, 4'h7}; // LI r1=7
        vt[1]  = '{enc(3'b010, 1'b0, 2'd2, 2'd1, 4'h1), 4'hE, 2'd2, 1'b0, 4'b0101, 4'hE}; // ADD 7+7 overflow
        vt[2]  = '{enc(3'b000, 1'b1, 2'd0, 2'd0, 4'h9), 4'h9, 2'd0, 1'b0, 4'b0101, 4'h9}; // LI r0=1001
        vt[3]  = '{enc(3'b000, 1'b1, 2'd1, 2'd0, 4'h7), 4'h7, 2'd1, 1'b0, 4'b0101, 4'h7}; // LI r1=0111
        vt[4]  = '{enc(3'b110, 1'b0, 2'd3, 2'd1, 4'h1), 4'h0, 2'd3, 1'b0, 4'b1010, 4'h0}; // SUB r1-r1
        vt[5]  = '{enc(3'b110, 1'b0, 2'd2, 2'd0, 4'h1), 4'h2, 2'd2, 1'b0, 4'b1100, 4'h2}; // SUB r0-r1
        vt[6]  = '{enc(3'b000, 1'b1, 2'd1, 2'd0, 4'hF), 4'hF, 2'd1, 1'b0, 4'b1100, 4'hF}; // LI r1=1111
        vt[7]  = '{enc(3'b111, 1'b0, 2'd2, 2'd0, 4'h1), 4'h1, 2'd2, 1'b0, 4'b0000, 4'h1}; // SLT r0<r1
        vt[8]  = '{enc(3'b111, 1'b0, 2'd3, 2'd1, 4'h0), 4'h0, 2'd3, 1'b0, 4'b1010, 4'h0}; // SLT r1<r0
        vt[9]  = '{enc(3'b000, 1'b1, 2'd0, 2'd0, 4'hF), 4'hF, 2'd0, 1'b0, 4'b1010, 4'hF}; // LI r0=1111
        vt[10] = '{enc(3'b000, 1'b1, 2'd1, 2'd0, 4'h2), 4'h2, 2'd1, 1'b0, 4'b1010, 4'h2}; // LI r1=0010
        vt[11] = '{enc(3'b100, 1'b0, 2'd2, 2'd0, 4'h1), 4'hD, 2'd2, 1'b0, 4'b1001, 4'hD}; // AND-NOT
        vt[12] = '{enc(3'b001, 1'b0, 2'd3, 2'd1, 4'h0), 4'hF, 2'd3, 1'b0, 4'b1001, 4'hF}; // OR
        vt[13] = '{enc(3'b000, 1'b0, 2'd0, 2'd3, 4'h1), 4'h2, 2'd0, 1'b0, 4'b1000, 4'h2}; // AND
        vt[14] = '{enc(3'b011, 1'b0, 2'd1, 2'd2, 4'h2), 4'h0, 2'd1, 1'b1, 4'b1000, 4'h2}; // illegal
        vt[15] = '{enc(3'b010, 1'b0, 2'd1, 2'd0, 4'hC), 4'h4, 2'd1, 1'b0, 4'b0000, 4'h4}; // ADD, rt[3:2] ignored

        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state.
        chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
        chk("reset_in_ready",  {7'd0, in_ready}, 8'd1);
        chk("reset_flags",     {4'd0, flags}, 8'd0);
        chk("reset_alu_op",    {5'd0, alu_op}, 8'd0);

        // Table-driven vectors, applied one at a time from IDLE.
        for (int i = 0; i < 16; i++) begin
            logic [11:0] w;
            logic        is_alu;
            w = vt[i].instr;
            is_alu = (w[8] == 1'b0) && (w[11:9] != 3'b011);
            issue(w);
            if (is_alu) begin
                chk($sformatf("v%0d_exec_no_valid", i), {7'd0, out_valid}, 8'd0);
                chk($sformatf("v%0d_exec_alu_op", i), {5'd0, alu_op}, {5'd0, w[11:9]});
                step();
            end
            chk($sformatf("v%0d_out_valid", i), {7'd0, out_valid}, 8'd1);
            chk($sformatf("v%0d_out_result", i), {4'd0, out_result}, {4'd0, vt[i].res});
            chk($sformatf("v%0d_out_rd", i), {6'd0, out_rd}, {6'd0, vt[i].rd});
            chk($sformatf("v%0d_out_err", i), {7'd0, out_err}, {7'd0, vt[i].err});
            chk($sformatf("v%0d_flags", i), {4'd0, flags}, {4'd0, vt[i].fl});
            dbg_addr = w[7:6];
            #1;
            chk($sformatf("v%0d_dbg", i), {4'd0, dbg_data}, {4'd0, vt[i].dbg});
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d_retired", i), {7'd0, out_valid}, 8'd0);
        end

        // Final register-file contents after the table.
        for (int a = 0; a < 4; a++) begin
            logic [3:0] exp_rf [4];
            exp_rf[0] = 4'h2;
            exp_rf[1] = 4'h4;
            exp_rf[2] = 4'hD;
            exp_rf[3] = 4'hF;
            dbg_addr = 2'(a);
            #1;
            chk($sformatf("table_rf%0d", a), {4'd0, dbg_data}, {4'd0, exp_rf[a]});
        end

        // Backpressure: an AND-NOT completion (1111 & ~0010 = 1101) is held for 5 cycles.
        out_ready = 1'b1;
        issue(enc(3'b000, 1'b1, 2'd0, 2'd0, 4'hF));
        issue(enc(3'b000, 1'b1, 2'd1, 2'd0, 4'h2));
        issue(enc(3'b100, 1'b0, 2'd2, 2'd0, 4'h1));
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_out_valid", k), {7'd0, out_valid}, 8'd1);
            chk($sformatf("bp%0d_out_result", k), {4'd0, out_result}, 8'h0D);
            chk($sformatf("bp%0d_in_ready", k), {7'd0, in_ready}, 8'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_single_completion", {7'd0, out_valid}, 8'd0);
        step();
        chk("bp_still_idle", {7'd0, out_valid}, 8'd0);

        // Back-to-back read-after-write with out_ready held high.
        // The LI and SLT issues are accepted in DONE on the same edge that retires the previous completion.
        issue(enc(3'b000, 1'b1, 2'd0, 2'd0, 4'h9));
        t_first = cyc;
        issue(enc(3'b000, 1'b1, 2'd1, 2'd0, 4'hF));
        issue(enc(3'b111, 1'b0, 2'd2, 2'd0, 4'h1));
        issue(enc(3'b111, 1'b0, 2'd3, 2'd1, 4'h0));
        t_last = cyc;
        chk("raw_issue_cycles", 8'(t_last - t_first), 8'd4);
        step();
        chk("raw_last_valid", {7'd0, out_valid}, 8'd1);
        chk("raw_last_result", {4'd0, out_result}, 8'h00);
        dbg_addr = 2'd2;
        #1;
        chk("raw_dbg_r2", {4'd0, dbg_data}, 8'h01);
        dbg_addr = 2'd3;
        #1;
        chk("raw_dbg_r3", {4'd0, dbg_data}, 8'h00);
        step();

        // Reset asserted while an ADD is in EXEC.
        issue(enc(3'b000, 1'b1, 2'd1, 2'd0, 4'h7));
        issue(enc(3'b010, 1'b0, 2'd2, 2'd1, 4'h1));
        chk("rst_exec_alu_a", {4'd0, alu_a}, 8'h07);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_flags", {4'd0, flags}, 8'd0);
        chk("rst_out_result", {4'd0, out_result}, 8'd0);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            chk($sformatf("rst_rf%0d", a), {4'd0, dbg_data}, 8'd0);
        end
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_alu_op", {5'd0, alu_op}, 8'd0);
        step();
        chk("rst_dropped", {7'd0, out_valid}, 8'd0);
        dbg_addr = 2'd2;
        #1;
        chk("rst_r2_unwritten", {4'd0, dbg_data}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue and writeback stage that feeds the 4-bit ALU (`ALU4Bit`). It accepts 12-bit instructions over a valid/ready handshake and holds a 4-entry x 4-bit register file. For each instruction it drives the ALU operand and opcode ports, captures the ALU result into the destination register, and latches the status flags. The top level wires this block's `alu_*` ports to `ALU4Bit` and ties the ALU's `less` input to its `set` output.

## Interface
- No parameters; all widths are fixed by the 4-bit ALU.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage can accept an instruction.
- `in_instr` in 12: instruction word, with fields:
  - [11:9] op
  - [8] li
  - [7:6] rd
  - [5:4] rs
  - [3:0] rt/imm; rt is [1:0], and [3:2] are ignored when li=0.
- `alu_a` out 4: ALU operand a, equal to rf[rs].
- `alu_b` out 4: ALU operand b, equal to rf[rt].
- `alu_op` out 3: ALU op; bit [2] is also driven as the ALU binvert/carry-in.
- `alu_result` in 4: ALU result.
- `alu_cout` in 1, `alu_overflow` in 1, `alu_zero` in 1: ALU status.
- `out_valid` out 1: a completed instruction is presented.
- `out_ready` in 1: downstream accepts the completion.
- `out_result` out 4: value written to rd.
- `out_rd` out 2: destination register index.
- `out_err` out 1: the completed instruction was illegal (op=011).
- `flags` out 4: {C, V, Z, N}.
- `dbg_addr` in 2: debug read address.
- `dbg_data` out 4: rf[dbg_addr], combinational.

## Operation
- Op encoding (op[1:0] selects the function, op[2] inverts b and sets carry-in):
  - 000 AND
  - 001 OR
  - 010 ADD
  - 100 AND-NOT
  - 101 OR-NOT
  - 110 SUB
  - 111 SLT
  - 011 is illegal.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `in_ready`=1.
  - On in_valid with li=1: write imm into rf[rd] and go to DONE. Flags are unchanged.
  - On in_valid with li=0 and op≠011: latch op/rd/rs/rt and go to EXEC.
  - On in_valid with li=0 and op=011: go to DONE with `out_err`=1. rf and flags are unchanged, and `out_result`=0.
- EXEC:
  - `alu_a`/`alu_b`/`alu_op` are driven from the latched fields and the current rf.
  - At the clock edge: rf[rd]←alu_result; flags←{alu_cout, alu_overflow, alu_zero, alu_result[3]}; go to DONE.
- DONE:
  - `out_valid`=1, holding `out_result`/`out_rd`/`out_err` stable until out_ready.
  - On out_ready with no new instruction: go to IDLE.
- `in_ready` = IDLE | (DONE & out_ready). A new instruction accepted in DONE takes the same transitions as acceptance from IDLE.
- Flag rules:
  - Flags update only on a legal ALU op that completes EXEC.
  - For AND/OR ops, C and V take the raw ALU outputs.
- `alu_*` outputs are 0 outside EXEC.
- Reset, applied asynchronously at any time including mid-instruction:
  - State becomes IDLE; any in-flight instruction is dropped.
  - rf and flags are cleared to 0.
  - `out_valid`, `out_result`, `out_rd` and `out_err` are cleared to 0.
  - `in_ready` becomes 1 once reset deasserts.

## Timing
- An ALU op accepted at edge E0 occupies EXEC in the cycle after E0 and is written at edge E1; `out_valid`=1 after E1.
- LI and illegal ops accepted at E0 give `out_valid`=1 after E0.
- Throughput with `out_ready` held high:
  - ALU ops: one every 2 cycles.
  - LI: one per cycle.
- Read-after-write: an instruction reading a register written by the immediately preceding instruction sees the new value. Writes occur at the edge before its EXEC, so no bypass is needed.
- Backpressure: while `out_valid` & !`out_ready`, `in_ready`=0, and all outputs and rf hold.
- `dbg_data` reflects rf writes in the cycle after the write edge.
- Simultaneous in_valid and out_ready in DONE: the completion retires and the new instruction is accepted on the same edge.

## Test plan
- **Reset mid-EXEC.** Issue LI r1=7, then ADD r2=r1+r1, with reset asserted during EXEC.
  - Expected: rf all 0, flags 0000, `out_valid`=0, `in_ready`=1 after deassert.
- **Signed ADD overflow.** Issue LI r1=0111, then ADD r2=r1+r1.
  - Expected: `out_result`=1110 one cycle after EXEC, flags C=0 V=1 Z=0 N=1.
- **Zero result, back-to-back.** Issue LI r0=1001, LI r1=0111, then SUB r3=r1-r1 back-to-back.
  - Expected: `out_result`=0000, Z=1, C=1, V=0.
  - Also: SUB r2=r0-r1 gives 0010 with V=1.
- **SLT and RAW hazard.** Issue LI r0=1001, LI r1=1111, then SLT r2=r0<r1, then SLT r3=r1<r0 issued immediately after.
  - Expected: r2=0001, r3=0000 (`dbg_data` confirms).
- **Backpressure.** Hold `out_ready`=0 for 5 cycles after an AND-NOT of 1111 and 0010.
  - Expected: `out_result`=1101 stable, `in_ready`=0 throughout, exactly one completion when released.
- **Illegal op.** Issue op=011.
  - Expected: `out_err`=1, `out_result`=0, rf and flags unchanged, next instruction processed normally.
